// File: rtl/uart_rx_fifo_wr_if.sv
// Bundle between the UART receiver and its neighbours: the serial line and
// FIFO-full status come in, and the write strobe, data and status flags go out.
// Handshake: push is a single-cycle write strobe with dout valid in the same
// cycle. There is no ready; fifo_full is sampled only at the stop-bit decision,
// and a good byte that meets fifo_full=1 is dropped and reported as overrun.
interface uart_rx_fifo_wr_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 fifo_full;
    logic                 push;
    logic [DATA_BITS-1:0] dout;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
    logic [2:0]           state_dbg;

    // Line/FIFO side: drives the serial line and FIFO status, observes results
    modport master (
        output rx, fifo_full,
        input  push, dout, frame_err, overrun, busy, state_dbg
    );

    // Receiver side
    modport slave (
        input  rx, fifo_full,
        output push, dout, frame_err, overrun, busy, state_dbg
    );
endinterface

// File: rtl/uart_rx_fifo_wr.sv
// 8N1-style UART receiver feeding a byte FIFO. The serial input is
// double-synchronised, a falling edge starts a frame, every bit is sampled
// mid-bit, and good bytes are pushed with a single-cycle strobe. Framing
// errors and overruns are reported as single-cycle pulses.
module uart_rx_fifo_wr #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input logic             clk,
    input logic             rst,
    uart_rx_fifo_wr_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int IW           = 3;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_s_prev;
    logic [1:0]           sync_vld;
    logic                 armed;
    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic [DATA_BITS-1:0] dout_r;

    // Synchroniser, arming logic and the receive state machine.
    // sync_vld marks when rx_s carries a real line sample rather than the
    // reset value; armed then requires the line to be seen high once, so a
    // line still held low after reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_s_prev   <= 1'b1;
            sync_vld    <= 2'b00;
            armed       <= 1'b0;
            state       <= IDLE;
            bit_cnt     <= '0;
            idx         <= '0;
            shreg       <= '0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            dout_r      <= '0;
        end else begin
            rx_meta   <= bus.rx;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
            sync_vld  <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_s) begin
                armed <= 1'b1;
            end

            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (armed && rx_s_prev && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bit_cnt == CNT_HALF) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        // A start bit that is gone by mid-bit was a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt     <= '0;
                        shreg[idx]  <= rx_s;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == CNT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            // Back to IDLE at the stop midpoint so a start edge
                            // half a bit later is still caught
                            state <= IDLE;
                            if (bus.fifo_full) begin
                                overrun_r <= 1'b1;
                            end else begin
                                push_r <= 1'b1;
                                dout_r <= shreg;
                            end
                        end else begin
                            frame_err_r <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                BRK: begin
                    bit_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.push      = push_r;
    assign bus.dout      = dout_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = (state != IDLE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Directed bench for uart_rx_fifo_wr at 10 clocks per bit.
module tb_uart_rx_fifo_wr;
    localparam int CPB = 10;

    logic clk;
    logic rst;
    int   cyc;

    uart_rx_fifo_wr_if #(.DATA_BITS(8)) bus ();

    uart_rx_fifo_wr #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .DATA_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] push_q[$];
    int         push_cyc_q[$];
    int         push_cnt   = 0;
    int         fe_cnt     = 0;
    int         ov_cnt     = 0;
    int         excl_bad   = 0;
    int         pulse_bad  = 0;
    int         busy_bad   = 0;
    logic       push_d     = 1'b0;
    logic       fe_d       = 1'b0;
    logic       ov_d       = 1'b0;

    // Event monitor sampling on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.push) begin
                push_cnt++;
                push_q.push_back(bus.dout);
                push_cyc_q.push_back(cyc);
                if (bus.busy) busy_bad++;
            end
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun) ov_cnt++;
            if ((32'(bus.push) + 32'(bus.frame_err) + 32'(bus.overrun)) > 1) excl_bad++;
            if ((bus.push && push_d) || (bus.frame_err && fe_d) || (bus.overrun && ov_d))
                pulse_bad++;
        end
        push_d = bus.push;
        fe_d   = bus.frame_err;
        ov_d   = bus.overrun;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Start bit, 8 data bits LSB first, then the given stop-bit level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(CPB);
        end
        bus.rx = stop_bit;
        tick(CPB);
    endtask

    int         t0;
    int         lat;
    int         base;
    logic [7:0] got;

    initial begin
        rst           = 1'b1;
        bus.rx        = 1'b1;
        bus.fifo_full = 1'b0;
        tick(5);
        chk("rst_push", 32'(bus.push), 32'h0);
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_state", 32'(bus.state_dbg), 32'h0);
        rst = 1'b0;
        tick(20);

        // 1: single good frame, latency and busy
        t0 = cyc;
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        tick(5);
        chk("t1_push_cnt", 32'(push_cnt), 32'd1);
        chk("t1_dout", 32'(bus.dout), 32'hA5);
        lat = (push_cyc_q.size() > 0) ? push_cyc_q[0] - t0 : -1;
        chk("t1_latency_96_98", 32'(lat >= 96 && lat <= 98), 32'h1);
        chk("t1_no_fe", 32'(fe_cnt), 32'd0);
        chk("t1_no_ov", 32'(ov_cnt), 32'd0);
        chk("t1_busy_idle", 32'(bus.busy), 32'h0);

        // 2: short glitch, then a real frame
        bus.rx = 1'b0;
        tick(3);
        bus.rx = 1'b1;
        tick(20);
        chk("t2_glitch_no_push", 32'(push_cnt), 32'd1);
        chk("t2_glitch_idle", 32'(bus.state_dbg), 32'h0);
        chk("t2_glitch_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);
        send_frame(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        tick(5);
        chk("t2_push_cnt", 32'(push_cnt), 32'd2);
        chk("t2_dout", 32'(bus.dout), 32'h3C);

        // 3: framing error, break, recovery
        send_frame(8'h5A, 1'b0);
        tick(40);
        chk("t3_fe_cnt", 32'(fe_cnt), 32'd1);
        chk("t3_no_push", 32'(push_cnt), 32'd2);
        chk("t3_break_state", 32'(bus.state_dbg), 32'h4);
        chk("t3_break_busy", 32'(bus.busy), 32'h1);
        bus.rx = 1'b1;
        tick(20);
        chk("t3_break_idle", 32'(bus.state_dbg), 32'h0);
        send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h11);
        tick(20);
        chk("t3_push_cnt", 32'(push_cnt), 32'd3);
        chk("t3_dout", 32'(bus.dout), 32'h11);
        chk("t3_fe_once", 32'(fe_cnt), 32'd1);

        // 4: overrun while FIFO full, then normal push
        bus.fifo_full = 1'b1;
        send_frame(8'h77, 1'b1);
        tick(5);
        bus.fifo_full = 1'b0;
        chk("t4_ov_cnt", 32'(ov_cnt), 32'd1);
        chk("t4_no_push", 32'(push_cnt), 32'd3);
        chk("t4_dout_held", 32'(bus.dout), 32'h11);
        send_frame(8'h78, 1'b1);
        exp_q.push_back(8'h78);
        tick(5);
        chk("t4_push_cnt", 32'(push_cnt), 32'd4);
        chk("t4_dout", 32'(bus.dout), 32'h78);

        // 5: reset in the middle of 0xC3 (bit 4 is 0)
        bus.rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx = ((i == 0) || (i == 1)) ? 1'b1 : 1'b0;
            tick(CPB);
        end
        bus.rx = 1'b0;
        tick(5);
        chk("t5_busy_before_rst", 32'(bus.busy), 32'h1);
        rst    = 1'b1;
        bus.rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("t5_push", 32'(bus.push), 32'h0);
        chk("t5_dout", 32'(bus.dout), 32'h0);
        chk("t5_flags", 32'({bus.frame_err, bus.overrun}), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);
        tick(120);
        chk("t5_no_push", 32'(push_cnt), 32'd4);
        chk("t5_no_flags", 32'(fe_cnt + ov_cnt), 32'd2);
        send_frame(8'h96, 1'b1);
        exp_q.push_back(8'h96);
        tick(5);
        chk("t5_push_cnt", 32'(push_cnt), 32'd5);
        chk("t5_dout", 32'(bus.dout), 32'h96);

        // 6: back-to-back frames with no idle gap
        base = push_cyc_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        tick(5);
        chk("t6_push_cnt", 32'(push_cnt), 32'd8);
        chk("t6_gap1", 32'((push_cyc_q.size() >= base + 2) ? push_cyc_q[base+1] - push_cyc_q[base] : -1), 32'd100);
        chk("t6_gap2", 32'((push_cyc_q.size() >= base + 3) ? push_cyc_q[base+2] - push_cyc_q[base+1] : -1), 32'd100);
        chk("t6_flags", 32'(fe_cnt + ov_cnt), 32'd2);

        // Scoreboard: pushed bytes in order
        chk("sb_count", 32'(push_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < push_q.size()) ? push_q[i] : 8'hXX;
            chk($sformatf("sb_byte%0d", i), 32'(got), 32'(exp_q[i]));
        end
        chk("excl_flags", 32'(excl_bad), 32'd0);
        chk("pulse_width", 32'(pulse_bad), 32'd0);
        chk("busy_at_push", 32'(busy_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
